// File: rtl/key_sched_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the key schedule
// and the byte S-box used by both the key schedule and the data path.
package key_sched_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box = affine(b^254); b^254 is the field inverse and maps 0 to 0
    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = gf_mul(b, b);
        for (int i = 32'sd1; i < 32'sd8; i++) begin
            inv = gf_mul(inv, sq);
            sq  = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sched_sbox.sv
// Combinational AES byte S-box; four of these form SubWord in the key schedule.
module key_sched_sbox
    import key_sched_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox_calc(din);

endmodule

// File: rtl/key_sched.sv
// AES-128 key schedule: expands key_in into round keys 0..NUM_ROUNDS, one per
// cycle, each tagged with its round address; hold freezes the schedule.
module key_sched
    import key_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      key_in,
    input  logic              hold,
    output logic              busy,
    output logic              rkey_valid,
    output logic [127:0]      rkey,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROUNDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    ks_state_e         state_r, state_s;
    logic [127:0]      rkey_r, rkey_s, next_key_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [7:0]        rcon_r, rcon_s;
    logic              busy_r, busy_s;
    logic              valid_r, valid_s;
    logic              done_r, done_s;
    logic [31:0]       rot_s, sub_s, t_s;
    logic [31:0]       w0_s, w1_s, w2_s, w3_s;

    // RotWord of the last word feeds SubWord
    assign rot_s = {rkey_r[23:0], rkey_r[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_sched_sbox u_sbox (
            .din  (rot_s[8*g +: 8]),
            .dout (sub_s[8*g +: 8])
        );
    end

    assign t_s        = sub_s ^ {rcon_r, 24'h000000};
    assign w0_s       = rkey_r[127:96] ^ t_s;
    assign w1_s       = rkey_r[95:64]  ^ w0_s;
    assign w2_s       = rkey_r[63:32]  ^ w1_s;
    assign w3_s       = rkey_r[31:0]   ^ w2_s;
    assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

    // Next-state and next-output logic; hold leaves every register untouched
    always_comb begin
        state_s = state_r;
        rkey_s  = rkey_r;
        addr_s  = addr_r;
        rcon_s  = rcon_r;
        busy_s  = busy_r;
        valid_s = valid_r;
        done_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    rkey_s  = key_in;
                    addr_s  = ADDR_ZERO;
                    rcon_s  = RCON_INIT;
                    busy_s  = 1'b1;
                    valid_s = 1'b1;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hold) begin
                    state_s = ST_RUN;
                end else if (addr_r == LAST_ADDR) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                    done_s  = 1'b0;
                end else begin
                    rkey_s  = next_key_s;
                    addr_s  = addr_r + ADDR_ONE;
                    rcon_s  = xtime(rcon_r);
                    done_s  = (addr_r == (LAST_ADDR - ADDR_ONE));
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                valid_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State, schedule and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rkey_r  <= 128'h0;
            addr_r  <= ADDR_ZERO;
            rcon_r  <= RCON_INIT;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rkey_r  <= rkey_s;
            addr_r  <= addr_s;
            rcon_r  <= rcon_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign busy       = busy_r;
    assign rkey_valid = valid_r;
    assign rkey       = rkey_r;
    assign addr       = addr_r;
    assign done       = done_r;

endmodule
